// File: rtl/boot_test_ctrl.sv
// Self-test sequencer: loads a program image over the Ext_* port,
// runs the core, then latches a pass/fail/timeout verdict.
module boot_test_ctrl #(
  parameter logic [31:0] BASE_ADDR      = 32'd0,
  parameter int unsigned MAX_WORDS      = 64,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter logic [31:0] PASS_ADDR      = 32'd100,
  parameter logic [31:0] PASS_DATA      = 32'd25,
  parameter logic [31:0] IGNORE_ADDR    = 32'd96
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ld_valid,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        core_reset,
  output logic        Ext_MemWrite,
  output logic [31:0] Ext_WriteData,
  output logic [31:0] Ext_DataAdr,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        fail,
  output logic        timeout,
  output logic [31:0] run_cycles
);

  localparam int IDX_W = $clog2(MAX_WORDS) + 1;
  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(MAX_WORDS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MAX_WORDS - 1);
  localparam logic [31:0] RUN_LIMIT = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, SETTLE, RUN, DONE
  } state_t;

  state_t state, stateNext;
  logic [IDX_W-1:0] wordIdx;
  logic handshake;
  logic lastWord;
  logic passHit;
  logic failHit;
  logic timeHit;
  logic launch;

  assign handshake = ld_valid && ld_ready;
  assign lastWord  = ld_last || (wordIdx == IDX_LAST);
  assign passHit   = MemWrite
                  && (DataAdr == PASS_ADDR)
                  && (WriteData == PASS_DATA);
  // A wrong-data store to PASS_ADDR is a failure too.
  assign failHit   = MemWrite
                  && (DataAdr != IGNORE_ADDR)
                  && !passHit;
  assign timeHit   = (run_cycles == RUN_LIMIT);
  assign launch    = start && ((state == IDLE) || (state == DONE));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:   if (start) stateNext = LOAD;
      LOAD:   if (handshake && lastWord) stateNext = SETTLE;
      SETTLE: stateNext = RUN;
      RUN:    if (passHit || failHit || timeHit) stateNext = DONE;
      DONE:   if (start) stateNext = LOAD;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    core_reset = 1'b1;
    ld_ready   = 1'b0;
    busy       = 1'b0;
    unique case (state)
      LOAD: begin
        ld_ready = (wordIdx < IDX_MAX);
        busy     = 1'b1;
      end
      SETTLE: busy = 1'b1;
      RUN: begin
        core_reset = 1'b0;
        busy       = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      Ext_MemWrite  <= 1'b0;
      Ext_WriteData <= '0;
      Ext_DataAdr   <= '0;
      wordIdx       <= '0;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail          <= 1'b0;
      timeout       <= 1'b0;
      run_cycles    <= '0;
    end else begin
      Ext_MemWrite <= 1'b0;
      if (launch) begin
        wordIdx    <= '0;
        done       <= 1'b0;
        pass       <= 1'b0;
        fail       <= 1'b0;
        timeout    <= 1'b0;
        run_cycles <= '0;
      end
      if ((state == LOAD) && handshake) begin
        Ext_MemWrite  <= 1'b1;
        Ext_WriteData <= ld_data;
        Ext_DataAdr   <= BASE_ADDR + (32'(wordIdx) << 2);
        wordIdx       <= wordIdx + 1'b1;
      end
      if (state == RUN) begin
        run_cycles <= run_cycles + 32'd1;
        if (passHit) begin
          pass <= 1'b1;
          done <= 1'b1;
        end else if (failHit) begin
          fail <= 1'b1;
          done <= 1'b1;
        end else if (timeHit) begin
          timeout <= 1'b1;
          done    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_boot_test_ctrl.sv
// Scoreboard bench for boot_test_ctrl: Ext writes and verdicts
// are queued by stimulus and checked by independent monitors.
module tb_boot_test_ctrl;

  localparam logic [31:0] BASE = 32'd0;
  localparam int MAXW = 4;
  localparam int TOC  = 16;

  logic clk, reset, start;
  logic ld_valid, ld_last, ld_ready;
  logic [31:0] ld_data;
  logic core_reset, Ext_MemWrite;
  logic [31:0] Ext_WriteData, Ext_DataAdr;
  logic MemWrite;
  logic [31:0] DataAdr, WriteData;
  logic busy, done, pass, fail, timeout;
  logic [31:0] run_cycles;

  boot_test_ctrl #(
    .BASE_ADDR(BASE),
    .MAX_WORDS(MAXW),
    .TIMEOUT_CYCLES(TOC),
    .PASS_ADDR(32'd100),
    .PASS_DATA(32'd25),
    .IGNORE_ADDR(32'd96)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready),
    .core_reset(core_reset),
    .Ext_MemWrite(Ext_MemWrite),
    .Ext_WriteData(Ext_WriteData),
    .Ext_DataAdr(Ext_DataAdr),
    .MemWrite(MemWrite), .DataAdr(DataAdr),
    .WriteData(WriteData),
    .busy(busy), .done(done), .pass(pass),
    .fail(fail), .timeout(timeout),
    .run_cycles(run_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    int at;
  } wr_t;

  typedef struct {
    logic p;
    logic f;
    logic t;
    logic [31:0] rc;
  } vd_t;

  wr_t wrQ[$];
  vd_t vdQ[$];

  task automatic chk1(input string nm, input logic a, input logic e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %b expected %b", nm, a, e);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  always @(negedge clk) begin : monWr
    wr_t e;
    if (Ext_MemWrite === 1'b1) begin
      if (wrQ.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL ext_unexpected: got write %0h<=%0h expected none",
                 Ext_DataAdr, Ext_WriteData);
      end else begin
        e = wrQ.pop_front();
        chk32("ext_adr", Ext_DataAdr, e.adr);
        chk32("ext_dat", Ext_WriteData, e.dat);
        chk32("ext_latency", 32'(cyc), 32'(e.at));
      end
    end
  end

  logic prevDone = 1'b0;
  always @(negedge clk) begin : monVd
    vd_t v;
    if (done === 1'b1 && prevDone !== 1'b1) begin
      if (vdQ.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL verdict_unexpected: got p%b f%b t%b expected none",
                 pass, fail, timeout);
      end else begin
        v = vdQ.pop_front();
        chk1("vd_pass", pass, v.p);
        chk1("vd_fail", fail, v.f);
        chk1("vd_timeout", timeout, v.t);
        chk32("vd_run_cycles", run_cycles, v.rc);
        chk1("vd_core_reset", core_reset, 1'b1);
        chk1("vd_busy", busy, 1'b0);
      end
    end
    prevDone <= done;
  end

  int tbIdx = 0;

  task automatic doStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    tbIdx = 0;
    chk1("start_busy", busy, 1'b1);
    chk1("start_ready", ld_ready, 1'b1);
    chk1("start_done_clr", done, 1'b0);
    chk1("start_flags_clr", pass | fail | timeout, 1'b0);
    chk32("start_rc_clr", run_cycles, 32'd0);
  endtask

  task automatic sendWord(input logic [31:0] d, input logic last,
                          output bit acc);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    acc = 1'b0;
    if (ld_ready === 1'b1) begin
      wrQ.push_back('{BASE + 32'(tbIdx) * 32'd4, d, cyc + 1});
      tbIdx++;
      acc = 1'b1;
    end
    @(negedge clk);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic gap();
    ld_valid = 1'b0;
    ld_last  = 1'b1;
    ld_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    ld_last  = 1'b0;
  endtask

  task automatic waitRun();
    chk1("settle_core_reset", core_reset, 1'b1);
    chk1("settle_ready", ld_ready, 1'b0);
    chk1("settle_busy", busy, 1'b1);
    @(negedge clk);
    chk1("run_core_reset", core_reset, 1'b0);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    DataAdr   = a;
    WriteData = d;
    @(negedge clk);
    MemWrite  = 1'b0;
    DataAdr   = '0;
    WriteData = '0;
  endtask

  task automatic waitDone(input int lim, output int k);
    k = 0;
    while (done !== 1'b1 && k < lim) begin
      @(negedge clk);
      k++;
    end
    if (done !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL done_wait: got done=%b after %0d cycles expected 1",
               done, k);
    end
  endtask

  task automatic chkReset(input string tag);
    chk1({tag, "_core_reset"}, core_reset, 1'b1);
    chk1({tag, "_ready"}, ld_ready, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_done"}, done, 1'b0);
    chk1({tag, "_flags"}, pass | fail | timeout, 1'b0);
    chk1({tag, "_extwe"}, Ext_MemWrite, 1'b0);
    chk32({tag, "_rc"}, run_cycles, 32'd0);
    chk32({tag, "_extadr"}, Ext_DataAdr, 32'd0);
    chk32({tag, "_extdat"}, Ext_WriteData, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit acc;
    int k;
    logic [31:0] tw [6];
    tw[0] = 32'h100; tw[1] = 32'h101; tw[2] = 32'h102;
    tw[3] = 32'h103; tw[4] = 32'h104; tw[5] = 32'h105;
    reset = 1'b1;
    start = 1'b0;
    ld_valid = 1'b0;
    ld_last = 1'b0;
    ld_data = '0;
    MemWrite = 1'b0;
    DataAdr = '0;
    WriteData = '0;
    repeat (2) @(negedge clk);
    chkReset("rst");
    reset = 1'b0;
    @(negedge clk);

    // 3-word load with a gap, ignored store then pass
    doStart();
    sendWord(32'hA, 1'b0, acc);
    gap();
    sendWord(32'hB, 1'b0, acc);
    sendWord(32'hC, 1'b1, acc);
    waitRun();
    vdQ.push_back('{1'b1, 1'b0, 1'b0, 32'd5});
    store(32'd96, 32'd7);
    repeat (3) @(negedge clk);
    store(32'd100, 32'd25);
    waitDone(5, k);
    repeat (3) @(negedge clk);
    chk1("sticky_done", done, 1'b1);
    chk1("sticky_pass", pass, 1'b1);

    // wrong pass data is a failure; start in RUN is ignored
    doStart();
    sendWord(32'h1, 1'b1, acc);
    waitRun();
    vdQ.push_back('{1'b0, 1'b1, 1'b0, 32'd3});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    store(32'd100, 32'd24);
    waitDone(5, k);

    // timeout after exactly TOC run cycles
    doStart();
    sendWord(32'h2, 1'b1, acc);
    waitRun();
    vdQ.push_back('{1'b0, 1'b0, 1'b1, 32'(TOC)});
    waitDone(40, k);
    chk32("timeout_latency", 32'(k), 32'(TOC));

    // pass on the last run cycle beats timeout
    doStart();
    sendWord(32'h3, 1'b1, acc);
    waitRun();
    vdQ.push_back('{1'b1, 1'b0, 1'b0, 32'(TOC)});
    repeat (TOC - 1) @(negedge clk);
    store(32'd100, 32'd25);
    waitDone(3, k);

    // truncation at MAXW words with level ld_valid
    doStart();
    for (int i = 0; i < MAXW; i++) begin
      sendWord(tw[i], 1'b0, acc);
      chk1("trunc_acc", acc, 1'b1);
    end
    waitRun();
    ld_valid = 1'b1;
    ld_data  = tw[4];
    chk1("trunc_ready_run", ld_ready, 1'b0);
    @(negedge clk);
    ld_data  = tw[5];
    @(negedge clk);
    ld_valid = 1'b0;
    vdQ.push_back('{1'b0, 1'b0, 1'b1, 32'(TOC)});
    waitDone(40, k);

    // reset during the 2nd handshake, then a 1-word reload
    doStart();
    sendWord(32'h11, 1'b0, acc);
    ld_valid = 1'b1;
    ld_data  = 32'h22;
    reset = 1'b1;
    @(negedge clk);
    ld_valid = 1'b0;
    chkReset("midrst");
    reset = 1'b0;
    @(negedge clk);
    doStart();
    sendWord(32'h33, 1'b1, acc);
    waitRun();
    vdQ.push_back('{1'b1, 1'b0, 1'b0, 32'd1});
    store(32'd100, 32'd25);
    waitDone(3, k);

    repeat (3) @(negedge clk);
    chk32("wrq_drained", 32'(wrQ.size()), 32'd0);
    chk32("vdq_drained", 32'(vdQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/boot_test_ctrl.md
Name: boot_test_ctrl

Overview:
Sequencer that owns the RISC-V core's reset and external memory-write port for self-test runs. It holds the core in reset and streams a program image into memory through the Ext_* write port using a valid/ready word stream. It then releases the core and runs it. It watches the core's store bus for the pass signature, a stray store, or a cycle timeout, and reports a sticky verdict.

Parameters:
BASE_ADDR, 0, byte address of the first loaded word; word k is written to BASE_ADDR+4k
MAX_WORDS, 64, maximum words accepted per load (power of two, at least 2)
TIMEOUT_CYCLES, 1000, run cycles allowed before the timeout verdict
PASS_ADDR, 100, store address of the pass signature
PASS_DATA, 25, store data of the pass signature
IGNORE_ADDR, 96, store address tolerated during the run without a verdict

Ports:
clk  in  1  system clock; all logic is rising-edge
reset  in  1  synchronous, active-high controller reset
start  in  1  single-cycle pulse that begins a load-and-run sequence
ld_valid  in  1  image word valid
ld_data  in  32  image word
ld_last  in  1  marks the final image word; qualified by ld_valid
ld_ready  out  1  controller accepts an image word
core_reset  out  1  drives the core's reset input
Ext_MemWrite  out  1  external memory write enable
Ext_WriteData  out  32  external write data
Ext_DataAdr  out  32  external write byte address
MemWrite  in  1  core store enable
DataAdr  in  32  core store address
WriteData  in  32  core store data
busy  out  1  high in LOAD, SETTLE and RUN
done  out  1  verdict valid; sticky until the next start or reset
pass  out  1  pass signature seen
fail  out  1  store to a non-ignored, non-pass address seen
timeout  out  1  TIMEOUT_CYCLES elapsed with no verdict
run_cycles  out  32  core cycles counted in RUN

Behaviour:
- Reset state: IDLE. Values: core_reset=1, Ext_MemWrite=0, Ext_WriteData=0, Ext_DataAdr=0, ld_ready=0, busy=0, done=0, pass=0, fail=0, timeout=0, run_cycles=0, word index=0.
- States are IDLE, LOAD, SETTLE, RUN and DONE. core_reset=1 in every state except RUN.
- IDLE: when start=1, go to LOAD. This clears done, pass, fail, timeout, run_cycles and the word index.
- LOAD: ld_ready=1 while the word index is below MAX_WORDS.
  - A handshake occurs when ld_valid and ld_ready are both 1.
  - On the edge after a handshake, the controller registers Ext_MemWrite=1, Ext_WriteData=ld_data and Ext_DataAdr=BASE_ADDR+4*index, then increments the index. Write latency is exactly 1 cycle.
  - Ext_MemWrite=0 on every cycle not following a handshake. Gaps in ld_valid are allowed.
  - Load ends on a handshake with ld_last=1, or on the handshake that makes index==MAX_WORDS (truncate; later words are not accepted). Either way, go to SETTLE.
- SETTLE: exactly 1 cycle. core_reset stays 1 so the final write commits before the core runs. ld_ready=0. Next state is RUN.
- RUN: core_reset=0 and run_cycles increments once per cycle. On each cycle, evaluate the core's store bus in this priority order:
  1. MemWrite=1, DataAdr==PASS_ADDR and WriteData==PASS_DATA: set pass=1, done=1 and go to DONE.
  2. MemWrite=1 and DataAdr!=IGNORE_ADDR: set fail=1, done=1 and go to DONE. A store to PASS_ADDR with wrong data counts as fail.
  3. Otherwise, if run_cycles==TIMEOUT_CYCLES-1: set timeout=1, done=1 and go to DONE.
  - A store verdict takes priority over timeout when both occur in the same cycle.
- DONE: core_reset=1 and the verdict bits are held. start restarts the sequence from LOAD with flags cleared; start is not required to pass through IDLE.
- start is ignored in LOAD, SETTLE and RUN.
- At most one of pass, fail and timeout is ever 1.
- Comparisons use full-width, exact 32-bit equality. X/Z on the store bus counts as a mismatch.
- The word index counter is log2(MAX_WORDS)+1 bits wide. Ext_DataAdr is computed modulo 2^32.
- Reset asserted in any state, including mid-LOAD or mid-RUN, returns to the reset state on the next edge. The partial image is abandoned and core_reset is asserted immediately.
- Level-style ld_valid is permitted. ld_last asserted without ld_valid has no effect.

Test Plan:
- Stream 3 words (0xA, 0xB, 0xC; last on 0xC) with BASE_ADDR=0 -> Ext writes at addresses 0, 4, 8 with matching data, one cycle after each handshake. Then 1 SETTLE cycle, then core_reset falls.
- In RUN, drive a store (96, 7), then 4 cycles later a store (100, 25) -> pass=1 and done=1 on the following cycle; core_reset=1; run_cycles=5.
- In RUN, drive a store (100, 24) -> fail=1 and pass=0.
- In RUN, drive no stores with TIMEOUT_CYCLES=16 -> timeout=1 after exactly 16 RUN cycles. Repeat with a pass store on cycle 15 -> pass=1 and timeout=0.
- With MAX_WORDS=4, stream 6 words with no ld_last -> exactly 4 Ext writes; ld_ready=0 after the 4th handshake; sequence proceeds to SETTLE.
- Assert reset during the 2nd LOAD handshake -> next cycle is the reset state with no further Ext_MemWrite. Then start plus a 1-word load with ld_last -> write at BASE_ADDR.
